vram_write_scheduler: RTL and testbench
=======================================

// Module: vram_write_scheduler
// PURPOSE
// - Buffers CPU-side VRAM writes in a FIFO; replays them onto the GPU VRAM port (data/address) only while
//   the video-timing writable window is open, so the background/foreground fetch never sees a mid-frame write.
// - Sits between the CPU bus decode and gpu_m: one write per clock during writable, holds off otherwise.
// PARAMETERS
// - ADDR_W   `VRAM_ADDR_WIDTH  VRAM address width
// - DATA_W   8                 VRAM data width
// - DEPTH_LG 4                 log2 FIFO depth (DEPTH = 16 entries)
// PORTS
// - clk            in   1       pixel clock (12.5875 MHz); the only clock
// - rst            in   1       asynchronous, active-low reset
// - writable       in   1       from video_timing_m; high = VRAM may be written this cycle
// - flush          in   1       synchronous: discard all pending entries, clear overflow
// - cpu_wr_valid   in   1       CPU write request
// - cpu_wr_addr    in   ADDR_W  CPU write address
// - cpu_wr_data    in   DATA_W  CPU write data
// - cpu_wr_ready   out  1       FIFO not full; write accepted on valid&&ready at rising clk
// - vram_we        out  1       write strobe to gpu_m VRAM port
// - vram_address   out  ADDR_W  head-of-FIFO address
// - vram_data      out  DATA_W  head-of-FIFO data
// - fifo_count     out  DEPTH_LG+1  entries pending (0..DEPTH)
// - overflow       out  1       sticky: a write arrived while full and was dropped
// - busy           out  1       fifo_count != 0
// BEHAVIOUR
// - Reset (rst=0, async): FIFO empty, pointers 0, state IDLE, vram_we=0, cpu_wr_ready=1,
//   fifo_count=0, overflow=0, busy=0, vram_address/vram_data=0.
// - FIFO: DEPTH entries {addr,data}; wr/rd pointers DEPTH_LG+1 bits, wrap modulo 2*DEPTH; full when
//   pointers differ only in MSB, empty when equal. fifo_count = wr_ptr - rd_ptr (mod 2^(DEPTH_LG+1)).
// - push = cpu_wr_valid && cpu_wr_ready && !flush; cpu_wr_ready = !full (no combinational path from pop).
// - pop  = vram_we. Push and pop in same cycle: both occur, count unchanged (legal even when full; ready
//   still reads 0 that cycle since it depends only on full).
// - vram_we = (state==DRAIN) && writable && !empty && !flush; combinational from registered state/pointers.
// - vram_address/vram_data = entry at rd_ptr, held stable whenever vram_we=0; 0 when empty.
// - Latency: write accepted at edge N with writable high and FIFO previously empty -> vram_we high
//   in cycle N..N+1 (strobe sampled at edge N+1 by gpu_m); 1 cycle minimum.
// - FSM (registered, advances on clk):
//   IDLE  : empty. push -> DRAIN if writable else WAIT.
//   WAIT  : pending, window closed. writable -> DRAIN.
//   DRAIN : pop each cycle writable && !empty. Becoming empty (last pop, no push) -> IDLE;
//           writable low with entries pending -> WAIT.
//   flush in any state -> IDLE next cycle, rd_ptr<=wr_ptr, overflow<=0; push that cycle is ignored.
// - Ordering: strict FIFO; writes to the same address retire in acceptance order.
// - overflow sets on cpu_wr_valid && full && !flush; cleared only by flush or reset.
// - writable falling: vram_we drops the same cycle; head entry is not popped, retried next window.
// - Reset mid-drain: pending writes are lost; no partial strobe after rst falls.
// CONFIGURATION
// - VRAM_WSCHED_STATS_EN defined: adds outputs drop_count[15:0] (saturating count of dropped writes)
//   and peak_count[DEPTH_LG:0] (max fifo_count seen); both cleared by reset and flush.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - writable=1, 3 writes (0x010/0xA1,0x011/0xA2,0x012/0xA3) back-to-back -> vram_we 3 consecutive
//   cycles starting 1 cycle after first accept, same order; fifo_count returns to 0, state IDLE.
// - writable=0, 5 writes -> vram_we stays 0, fifo_count=5, state WAIT; raise writable -> 5 strobes in
//   5 consecutive cycles, in order.
// - writable=0, 17 writes -> cpu_wr_ready=0 after 16th, 17th dropped, overflow=1, fifo_count=16;
//   (STATS_EN: drop_count=1, peak_count=16); flush -> fifo_count=0, overflow=0, ready=1.
// - Draining 4 entries, drop writable after 2 strobes -> vram_we low that cycle, fifo_count=2 held;
//   writable high again -> remaining 2 retire, no duplicate or lost write.
// - FIFO full, writable=1, simultaneous push+pop for 20 cycles -> count stays 16, pointers wrap cleanly,
//   order preserved across wrap.
// - Assert rst=0 asynchronously mid-DRAIN (between edges) -> vram_we=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/vram_write_scheduler.sv
// rtl/vram_write_scheduler.sv - CPU-to-VRAM write FIFO replayed only inside the video writable window
// Optional: define VRAM_WSCHED_STATS_EN to add drop_count_o and peak_count_o.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 13
`endif

module vram_write_scheduler #(
    parameter int ADDR_W   = `VRAM_ADDR_WIDTH,
    parameter int DATA_W   = 8,
    parameter int DEPTH_LG = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              writable_i,
    input  logic              flush_i,
    input  logic              cpu_wr_valid_i,
    input  logic [ADDR_W-1:0] cpu_wr_addr_i,
    input  logic [DATA_W-1:0] cpu_wr_data_i,
    output logic              cpu_wr_ready_o,
    output logic              vram_we_o,
    output logic [ADDR_W-1:0] vram_address_o,
    output logic [DATA_W-1:0] vram_data_o,
    output logic [DEPTH_LG:0] fifo_count_o,
    output logic              overflow_o,
`ifdef VRAM_WSCHED_STATS_EN
    output logic [15:0]       drop_count_o,
    output logic [DEPTH_LG:0] peak_count_o,
`endif
    output logic              busy_o
);

    localparam int DEPTH = 1 << DEPTH_LG;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DEPTH_LG:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LG:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LG:0]   count_d;
    logic                overflow_q, overflow_d;

    logic [ADDR_W-1:0]   addr_mem [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];

    logic full, empty, push, pop, drop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {DEPTH_LG{1'b0}}});

    // The strobe comes only from registered state/pointers plus window and flush,
    // so ready never depends on the same-cycle pop.
    assign vram_we_o = (state_q == S_DRAIN) && writable_i && !empty && !flush_i;
    assign pop       = vram_we_o;

    // A write presented while full still lands if the head retires in the same cycle.
    assign push = cpu_wr_valid_i && (!full || pop) && !flush_i;
    assign drop = cpu_wr_valid_i && full && !pop && !flush_i;

    assign cpu_wr_ready_o = !full;
    assign fifo_count_o   = wr_ptr_q - rd_ptr_q;
    assign busy_o         = !empty;
    assign overflow_o     = overflow_q;

    assign vram_address_o = empty ? '0 : addr_mem[rd_ptr_q[DEPTH_LG-1:0]];
    assign vram_data_o    = empty ? '0 : data_mem[rd_ptr_q[DEPTH_LG-1:0]];

    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{DEPTH_LG{1'b0}}, push};
        rd_ptr_d   = flush_i ? wr_ptr_q : (rd_ptr_q + {{DEPTH_LG{1'b0}}, pop});
        count_d    = wr_ptr_d - rd_ptr_d;
        overflow_d = flush_i ? 1'b0 : (overflow_q | drop);
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (push) state_d = writable_i ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (writable_i) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    if (count_d == '0)    state_d = S_IDLE;
                    else if (!writable_i) state_d = S_WAIT;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the head outputs are masked while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr_q[DEPTH_LG-1:0]] <= cpu_wr_addr_i;
            data_mem[wr_ptr_q[DEPTH_LG-1:0]] <= cpu_wr_data_i;
        end
    end

`ifdef VRAM_WSCHED_STATS_EN
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [DEPTH_LG:0] peak_q, peak_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        peak_d     = peak_q;
        if (flush_i) begin
            drop_cnt_d = '0;
            peak_d     = '0;
        end else begin
            if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
            if (count_d > peak_q)                 peak_d     = count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt_q <= '0;
            peak_q     <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            peak_q     <= peak_d;
        end
    end

    assign drop_count_o = drop_cnt_q;
    assign peak_count_o = peak_q;
`endif

endmodule

// File: tb/tb_vram_write_scheduler.sv
// tb/tb_vram_write_scheduler.sv - directed self-checking bench for vram_write_scheduler
module tb_vram_write_scheduler;

    logic        clk;
    logic        rst_n;
    logic        writable;
    logic        flush;
    logic        valid;
    logic [12:0] addr;
    logic [7:0]  data;
    logic        ready;
    logic        we;
    logic [12:0] vaddr;
    logic [7:0]  vdata;
    logic [4:0]  count;
    logic        overflow;
    logic        busy;
`ifdef VRAM_WSCHED_STATS_EN
    logic [15:0] drop_count;
    logic [4:0]  peak_count;
`endif

    int tests = 0;
    int fails = 0;

    vram_write_scheduler #(.ADDR_W(13), .DATA_W(8), .DEPTH_LG(4)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .writable_i     (writable),
        .flush_i        (flush),
        .cpu_wr_valid_i (valid),
        .cpu_wr_addr_i  (addr),
        .cpu_wr_data_i  (data),
        .cpu_wr_ready_o (ready),
        .vram_we_o      (we),
        .vram_address_o (vaddr),
        .vram_data_o    (vdata),
        .fifo_count_o   (count),
        .overflow_o     (overflow),
`ifdef VRAM_WSCHED_STATS_EN
        .drop_count_o   (drop_count),
        .peak_count_o   (peak_count),
`endif
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #40 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [12:0] a, input logic [7:0] d);
        valid = v;
        addr  = a;
        data  = d;
    endtask

    initial begin
        rst_n = 1'b0; writable = 1'b0; flush = 1'b0;
        drive(1'b0, 13'h0, 8'h0);
        cyc(); #1;
        chk("rst_ready", ready, 1);
        chk("rst_we", we, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", vaddr, 0);
        chk("rst_data", vdata, 0);
        cyc(); rst_n = 1'b1;

        // back-to-back writes with the window open
        writable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); drive(1'b1, 13'(32'h010 + i), 8'(32'hA1 + i)); #1;
            if (i == 0) begin
                chk("t1_we_first", we, 0);
            end else begin
                chk("t1_we", we, 1);
                chk("t1_addr", vaddr, 32'h010 + i - 1);
                chk("t1_data", vdata, 32'hA1 + i - 1);
            end
        end
        cyc(); drive(1'b0, 13'h0, 8'h0); #1;
        chk("t1_we_last", we, 1);
        chk("t1_addr_last", vaddr, 32'h012);
        chk("t1_data_last", vdata, 32'hA3);
        cyc(); #1;
        chk("t1_we_done", we, 0);
        chk("t1_count", count, 0);
        chk("t1_busy", busy, 0);
        chk("t1_state", 32'(dut.state_q), 0);

        // window closed: queue 5, then release
        writable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); drive(1'b1, 13'(32'h100 + i), 8'(32'h50 + i)); #1;
            chk("t2_we_hold", we, 0);
        end
        cyc(); drive(1'b0, 13'h0, 8'h0); writable = 1'b1; #1;
        chk("t2_count", count, 5);
        chk("t2_state_wait", 32'(dut.state_q), 1);
        chk("t2_we_wait", we, 0);
        chk("t2_head_addr", vaddr, 32'h100);
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            chk("t2_we", we, 1);
            chk("t2_addr", vaddr, 32'h100 + i);
            chk("t2_data", vdata, 32'h50 + i);
        end
        cyc(); #1;
        chk("t2_we_done", we, 0);
        chk("t2_count_done", count, 0);
        chk("t2_state_idle", 32'(dut.state_q), 0);

        // overfill by one, then flush
        writable = 1'b0;
        for (int i = 0; i < 17; i++) begin
            cyc(); drive(1'b1, 13'(32'h200 + i), 8'(i)); #1;
            chk("t3_ready", ready, (i < 16) ? 32'd1 : 32'd0);
        end
        cyc(); drive(1'b0, 13'h0, 8'h0); #1;
        chk("t3_overflow", overflow, 1);
        chk("t3_count", count, 16);
        chk("t3_ready_full", ready, 0);
        chk("t3_we", we, 0);
        chk("t3_head_addr", vaddr, 32'h200);
`ifdef VRAM_WSCHED_STATS_EN
        chk("t3_drop_count", drop_count, 1);
        chk("t3_peak_count", peak_count, 16);
`endif
        cyc(); flush = 1'b1;
        cyc(); flush = 1'b0; #1;
        chk("t3_flush_count", count, 0);
        chk("t3_flush_overflow", overflow, 0);
        chk("t3_flush_ready", ready, 1);
        chk("t3_flush_busy", busy, 0);
        chk("t3_flush_state", 32'(dut.state_q), 0);
`ifdef VRAM_WSCHED_STATS_EN
        chk("t3_flush_drop", drop_count, 0);
        chk("t3_flush_peak", peak_count, 0);
`endif

        // window closes mid-drain
        for (int i = 0; i < 4; i++) begin
            cyc(); drive(1'b1, 13'(32'h300 + i), 8'(32'hC0 + i)); #1;
        end
        cyc(); drive(1'b0, 13'h0, 8'h0); writable = 1'b1; #1;
        chk("t4_we_wait", we, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            chk("t4_we_a", we, 1);
            chk("t4_addr_a", vaddr, 32'h300 + i);
        end
        cyc(); writable = 1'b0; #1;
        chk("t4_we_drop", we, 0);
        chk("t4_count_held", count, 2);
        chk("t4_addr_held", vaddr, 32'h302);
        cyc(); #1;
        chk("t4_count_held2", count, 2);
        chk("t4_state_wait", 32'(dut.state_q), 1);
        writable = 1'b1;
        for (int i = 2; i < 4; i++) begin
            cyc(); #1;
            chk("t4_we_b", we, 1);
            chk("t4_addr_b", vaddr, 32'h300 + i);
            chk("t4_data_b", vdata, 32'hC0 + i);
        end
        cyc(); #1;
        chk("t4_we_done", we, 0);
        chk("t4_count_done", count, 0);

        // full FIFO with simultaneous push and pop across pointer wrap
        writable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc(); drive(1'b1, 13'(32'h400 + i), 8'(i));
        end
        cyc(); drive(1'b0, 13'h0, 8'h0); writable = 1'b1; #1;
        chk("t5_count_full", count, 16);
        for (int k = 0; k < 20; k++) begin
            cyc(); drive(1'b1, 13'(32'h410 + k), 8'(16 + k)); #1;
            chk("t5_we", we, 1);
            chk("t5_addr", vaddr, 32'h400 + k);
            chk("t5_data", vdata, k);
            chk("t5_count", count, 16);
            chk("t5_ready", ready, 0);
        end
        for (int k = 20; k < 36; k++) begin
            cyc();
            if (k == 20) drive(1'b0, 13'h0, 8'h0);
            #1;
            chk("t5_drain_we", we, 1);
            chk("t5_drain_addr", vaddr, 32'h400 + k);
            chk("t5_drain_data", vdata, k);
        end
        chk("t5_no_overflow", overflow, 0);
        cyc(); #1;
        chk("t5_count_done", count, 0);
        chk("t5_state_idle", 32'(dut.state_q), 0);

        // asynchronous reset in the middle of a drain
        writable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); drive(1'b1, 13'(32'h500 + i), 8'(32'hE0 + i));
        end
        cyc(); drive(1'b0, 13'h0, 8'h0); writable = 1'b1;
        cyc(); #1;
        chk("t6_we_pre", we, 1);
        chk("t6_addr_pre", vaddr, 32'h500);
        #10; rst_n = 1'b0; #1;
        chk("t6_we", we, 0);
        chk("t6_count", count, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ready", ready, 1);
        chk("t6_overflow", overflow, 0);
        chk("t6_addr", vaddr, 0);
        chk("t6_data", vdata, 0);
        cyc(); cyc(); rst_n = 1'b1; #1;
        cyc(); #1;
        chk("t6_we_after", we, 0);
        chk("t6_count_after", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
